// File: rtl/wrapper.sv
// wrapper: colour-selector shell around a hardwired program sequencer.
// A 9-bit byte program counter loops through 0x040..0x128. At 0x044 the
// push-buttons are sampled. At 0x124 the DIP-selected RGB565 channel is
// stepped up or down by one with saturation. The result drives the
// seven-segment display, the LEDs and the OLED data bus.
module wrapper #(
    parameter int N_LEDs_OUT = 8,
    parameter int N_DIPs     = 16,
    parameter int N_PBs      = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_DIPs-1:0]     DIP,
    input  logic [N_PBs-1:0]      PB,
    output logic [N_LEDs_OUT-1:0] LED_OUT,
    output logic [6:0]            LED_PC,
    output logic [31:0]           SEVENSEGHEX,
    output logic [7:0]            UART_TX,
    input  logic                  UART_TX_ready,
    output logic                  UART_TX_valid,
    input  logic [7:0]            UART_RX,
    input  logic                  UART_RX_valid,
    output logic                  UART_RX_ack,
    output logic                  OLED_Write,
    output logic [6:0]            OLED_Col,
    output logic [5:0]            OLED_Row,
    output logic [23:0]           OLED_Data,
    input  logic [31:0]           ACCEL_Data,
    output logic                  ACCEL_DReady
);

    // Program addresses of the fixed loop.
    localparam logic [8:0] PC_RESET = 9'h000;
    localparam logic [8:0] PC_LOOP  = 9'h040;
    localparam logic [8:0] PC_READ  = 9'h044;
    localparam logic [8:0] PC_WRITE = 9'h124;
    localparam logic [8:0] PC_LAST  = 9'h128;

    // Button codes that move the selected channel. Any other code holds it.
    localparam logic [N_PBs-1:0] PB_UP   = N_PBs'(3'b100);
    localparam logic [N_PBs-1:0] PB_DOWN = N_PBs'(3'b001);

    // Increment or decrement a 5-bit field, clamping at 0 and 31.
    function automatic logic [4:0] sat_step5(input logic [4:0] val,
                                             input logic       up,
                                             input logic       dn);
        logic [4:0] res;
        res = val;
        if (up && (val != 5'h1F)) begin
            res = val + 5'd1;
        end else if (dn && (val != 5'h00)) begin
            res = val - 5'd1;
        end
        return res;
    endfunction

    // Increment or decrement a 6-bit field, clamping at 0 and 63.
    function automatic logic [5:0] sat_step6(input logic [5:0] val,
                                             input logic       up,
                                             input logic       dn);
        logic [5:0] res;
        res = val;
        if (up && (val != 6'h3F)) begin
            res = val + 6'd1;
        end else if (dn && (val != 6'h00)) begin
            res = val - 6'd1;
        end
        return res;
    endfunction

    logic [8:0]       r_pc;
    logic [N_PBs-1:0] r_pb_s;
    logic [15:0]      r_colour;
    logic             r_oled_wr;

    logic [8:0]       w_pc_next;
    logic             w_at_read;
    logic             w_at_write;
    logic             w_up;
    logic             w_dn;
    logic [4:0]       w_red;
    logic [5:0]       w_green;
    logic [4:0]       w_blue;
    logic [15:0]      w_colour_next;
    logic             w_unused;

    assign w_at_read  = (r_pc == PC_READ);
    assign w_at_write = (r_pc == PC_WRITE);
    assign w_up       = (r_pb_s == PB_UP);
    assign w_dn       = (r_pb_s == PB_DOWN);
    assign w_red      = r_colour[15:11];
    assign w_green    = r_colour[10:5];
    assign w_blue     = r_colour[4:0];

    // Next PC: sequential fetch, jumping back to the loop head after the last slot.
    always_comb begin
        w_pc_next = r_pc + 9'd4;
        if (r_pc == PC_LAST) begin
            w_pc_next = PC_LOOP;
        end
    end

    // Next colour: step only the DIP-selected channel; 2'b11 aliases red.
    always_comb begin
        w_colour_next = r_colour;
        case (DIP[1:0])
            2'b01:   w_colour_next[10:5]  = sat_step6(w_green, w_up, w_dn);
            2'b10:   w_colour_next[4:0]   = sat_step5(w_blue, w_up, w_dn);
            default: w_colour_next[15:11] = sat_step5(w_red, w_up, w_dn);
        endcase
    end

    // Program counter register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Button snapshot taken once per pass; later PB activity is ignored.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pb_s <= '0;
        end else if (w_at_read) begin
            r_pb_s <= PB;
        end
    end

    // Display register and its write strobe, both updated at the write slot.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_colour  <= 16'h0000;
            r_oled_wr <= 1'b0;
        end else begin
            r_oled_wr <= w_at_write;
            if (w_at_write) begin
                r_colour <= w_colour_next;
            end
        end
    end

    assign LED_OUT     = N_LEDs_OUT'(r_colour[15:8]);
    assign LED_PC      = r_pc[8:2];
    assign SEVENSEGHEX = {16'h0000, r_colour};
    assign OLED_Write  = r_oled_wr;
    assign OLED_Data   = {w_red, w_red[4:2], w_green, w_green[5:4], w_blue, w_blue[4:2]};

    // Peripherals this program does not use are held idle.
    assign UART_TX       = 8'h00;
    assign UART_TX_valid = 1'b0;
    assign UART_RX_ack   = 1'b0;
    assign OLED_Col      = 7'd0;
    assign OLED_Row      = 6'd0;
    assign ACCEL_DReady  = 1'b0;

    // Inputs that the program never reads.
    assign w_unused = ^{DIP[N_DIPs-1:2], UART_TX_ready, UART_RX, UART_RX_valid, ACCEL_Data};

endmodule

// File: tb/tb_wrapper.sv
// Directed bench for wrapper with a colour scoreboard.
module tb_wrapper;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] DIP;
    logic [2:0]  PB;
    logic [7:0]  LED_OUT;
    logic [6:0]  LED_PC;
    logic [31:0] SEVENSEGHEX;
    logic [7:0]  UART_TX;
    logic        UART_TX_ready;
    logic        UART_TX_valid;
    logic [7:0]  UART_RX;
    logic        UART_RX_valid;
    logic        UART_RX_ack;
    logic        OLED_Write;
    logic [6:0]  OLED_Col;
    logic [5:0]  OLED_Row;
    logic [23:0] OLED_Data;
    logic [31:0] ACCEL_Data;
    logic        ACCEL_DReady;

    always #5 CLK = ~CLK;

    wrapper dut (
        .CLK(CLK), .RESET(RESET), .DIP(DIP), .PB(PB),
        .LED_OUT(LED_OUT), .LED_PC(LED_PC), .SEVENSEGHEX(SEVENSEGHEX),
        .UART_TX(UART_TX), .UART_TX_ready(UART_TX_ready), .UART_TX_valid(UART_TX_valid),
        .UART_RX(UART_RX), .UART_RX_valid(UART_RX_valid), .UART_RX_ack(UART_RX_ack),
        .OLED_Write(OLED_Write), .OLED_Col(OLED_Col), .OLED_Row(OLED_Row),
        .OLED_Data(OLED_Data), .ACCEL_Data(ACCEL_Data), .ACCEL_DReady(ACCEL_DReady)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] q[$];
    logic [15:0] model_col;
    logic [15:0] shown;
    logic [8:0]  exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    // Reference model of one write-point update.
    function automatic logic [15:0] model_next(input logic [15:0] c, input logic [2:0] pb,
                                               input logic [1:0] dip);
        int r, g, b, d;
        r = int'(c[15:11]);
        g = int'(c[10:5]);
        b = int'(c[4:0]);
        d = (pb == 3'b100) ? 1 : ((pb == 3'b001) ? -1 : 0);
        if (dip == 2'b01)      g = clamp(g + d, 63);
        else if (dip == 2'b10) b = clamp(b + d, 31);
        else                   r = clamp(r + d, 31);
        return {5'(r), 6'(g), 5'(b)};
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] c);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = c[15:11];
        g = c[10:5];
        b = c[4:0];
        return {r, r[4:2], g, g[5:4], b, b[4:2]};
    endfunction

    // One clock: advance the PC model, pop the scoreboard at the post-write slot,
    // and compare every visible output.
    task automatic adv();
        @(posedge CLK);
        #1;
        exp_pc = (exp_pc == 9'h128) ? 9'h040 : exp_pc + 9'd4;
        chk("led_pc", {25'd0, LED_PC}, {25'd0, exp_pc[8:2]});
        chk("oled_write", {31'd0, OLED_Write}, {31'd0, exp_pc == 9'h128});
        if (exp_pc == 9'h128) begin
            chk("sb_pending", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) shown = q.pop_front();
        end
        chk("sevenseg", SEVENSEGHEX, {16'h0000, shown});
        chk("led_out", {24'd0, LED_OUT}, {24'd0, shown[15:8]});
        chk("oled_data", {8'd0, OLED_Data}, {8'd0, expand(shown)});
    endtask

    // One full loop pass; optionally change PB after the read point.
    task automatic do_pass(input logic [2:0] pb, input logic [1:0] dip,
                           input logic use_late, input logic [2:0] late);
        int n;
        PB  = pb;
        DIP = {14'h1A5A, dip};
        model_col = model_next(model_col, pb, dip);
        q.push_back(model_col);
        n = 0;
        do begin
            adv();
            n++;
            if (use_late && exp_pc == 9'h04C) PB = late;
        end while (exp_pc != 9'h128 && n < 100);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_led_pc"}, {25'd0, LED_PC}, 32'd0);
        chk({tag, "_sevenseg"}, SEVENSEGHEX, 32'd0);
        chk({tag, "_oled_write"}, {31'd0, OLED_Write}, 32'd0);
        chk({tag, "_led_out"}, {24'd0, LED_OUT}, 32'd0);
        chk({tag, "_oled_data"}, {8'd0, OLED_Data}, 32'd0);
    endtask

    initial begin
        RESET = 1'b0;
        PB = 3'b000;
        DIP = 16'h0000;
        UART_TX_ready = 1'b1;
        UART_RX = 8'hA5;
        UART_RX_valid = 1'b1;
        ACCEL_Data = 32'hDEADBEEF;
        model_col = 16'h0000;
        shown = 16'h0000;
        exp_pc = 9'h000;
        #12;
        check_reset_state("reset");
        chk("uart_tx", {24'd0, UART_TX}, 32'd0);
        chk("uart_tx_valid", {31'd0, UART_TX_valid}, 32'd0);
        chk("uart_rx_ack", {31'd0, UART_RX_ack}, 32'd0);
        chk("oled_col", {25'd0, OLED_Col}, 32'd0);
        chk("oled_row", {26'd0, OLED_Row}, 32'd0);
        chk("accel_dready", {31'd0, ACCEL_DReady}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Red ramps 1, 2, 3, then up to 31 and saturates.
        for (int i = 0; i < 3; i++) do_pass(3'b100, 2'b00, 1'b0, 3'b000);
        chk("red_after3", {27'd0, SEVENSEGHEX[15:11]}, 32'd3);
        for (int i = 0; i < 28; i++) do_pass(3'b100, 2'b00, 1'b0, 3'b000);
        chk("red_at_max", {27'd0, SEVENSEGHEX[15:11]}, 32'd31);
        do_pass(3'b100, 2'b00, 1'b0, 3'b000);
        chk("red_saturated", SEVENSEGHEX, 32'h0000F800);

        // Down to 3, then 2, 1, 0, 0, 0.
        for (int i = 0; i < 28; i++) do_pass(3'b001, 2'b00, 1'b0, 3'b000);
        chk("red_down_to3", SEVENSEGHEX, 32'h00001800);
        for (int i = 0; i < 5; i++) do_pass(3'b001, 2'b00, 1'b0, 3'b000);
        chk("red_floor", SEVENSEGHEX, 32'h00000000);

        // PB changes after the read point: this pass increments, next decrements.
        do_pass(3'b100, 2'b00, 1'b1, 3'b001);
        chk("late_inc", SEVENSEGHEX, 32'h00000800);
        do_pass(3'b001, 2'b00, 1'b0, 3'b000);
        chk("late_dec", SEVENSEGHEX, 32'h00000000);

        // Non-step button codes hold the colour.
        do_pass(3'b100, 2'b00, 1'b0, 3'b000);
        do_pass(3'b100, 2'b00, 1'b0, 3'b000);
        do_pass(3'b101, 2'b00, 1'b0, 3'b000);
        do_pass(3'b000, 2'b00, 1'b0, 3'b000);
        do_pass(3'b111, 2'b00, 1'b0, 3'b000);
        do_pass(3'b011, 2'b00, 1'b0, 3'b000);
        do_pass(3'b010, 2'b00, 1'b0, 3'b000);
        chk("hold_codes", SEVENSEGHEX, 32'h00001000);

        // DIP 11 aliases red; DIP 10 selects blue.
        do_pass(3'b100, 2'b11, 1'b0, 3'b000);
        do_pass(3'b100, 2'b10, 1'b0, 3'b000);
        do_pass(3'b100, 2'b10, 1'b0, 3'b000);
        do_pass(3'b001, 2'b10, 1'b0, 3'b000);
        chk("red3_blue1", SEVENSEGHEX, 32'h00001801);

        // Asynchronous reset in the middle of a pass with an increment pending.
        PB = 3'b100;
        DIP = 16'h0000;
        for (int i = 0; i < 100 && exp_pc != 9'h080; i++) adv();
        #2;
        RESET = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge CLK);
        RESET = 1'b1;
        exp_pc = 9'h000;
        model_col = 16'h0000;
        shown = 16'h0000;
        q.delete();

        // Green ramps to 63 and holds; red and blue stay 0.
        for (int i = 0; i < 64; i++) do_pass(3'b100, 2'b01, 1'b0, 3'b000);
        chk("green_max", SEVENSEGHEX, 32'h000007E0);
        chk("green_oled", {8'd0, OLED_Data}, 32'h0000FF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
